riscv_instr_sequencer: RTL and testbench
========================================

// Module: riscv_instr_sequencer
// PURPOSE
//  Parametrised, self-checking instruction driver for riscv_top.
//  - Holds a loadable program of DEPTH entries: {instruction, expected rd, check flag}.
//  - On start, issues entries 0..prog_len-1 to the core's addr input, one every LAT+1 cycles.
//  - Samples rd after each issue, compares it to the expected value, and accumulates pass/fail results.
//  - Replaces hand-timed stimulus with a reusable on-chip bring-up/regression engine.
// PARAMETERS
//  WIDTH      32            instruction / data width
//  DEPTH      16            program entries (power of 2, >=2); AW = $clog2(DEPTH)
//  LAT        1             cycles from issue to valid rd (>=1)
//  NOP_INSTR  32'h00000013  driven on instr when not issuing (addi x0,x0,0)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-low reset
//  load_we        in   1        program write strobe (accepted in IDLE/DONE only)
//  load_idx       in   AW       program entry index
//  load_instr     in   WIDTH    instruction for the entry
//  load_exp       in   WIDTH    expected rd for the entry
//  load_chk       in   1        1 = compare rd for this entry
//  prog_len       in   AW+1     entries to run; sampled on start; values >DEPTH clamp to DEPTH
//  start          in   1        run request (accepted in IDLE/DONE only)
//  instr          out  WIDTH    to core addr
//  instr_vld      out  1        1 during the issue cycle
//  rd             in   WIDTH    core result
//  busy           out  1        run in progress
//  done           out  1        run complete; held until next accepted start
//  pass_cnt       out  AW+1     checked entries that matched
//  fail_cnt       out  AW+1     checked entries that mismatched
//  first_fail_vld out  1        at least one mismatch this run
//  first_fail_idx out  AW       index of the first mismatch
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; instr=NOP_INSTR; instr_vld, busy, done, counters,
//    first_fail_* all 0. Program memory is NOT reset; contents are retained across reset.
//  - FSM states: IDLE, ISSUE, WAIT, DONE.
//    - IDLE/DONE + start:
//      - Clears counters and first_fail_* and deasserts done.
//      - Latches len = min(prog_len, DEPTH) and sets idx = 0.
//      - len==0: go to DONE immediately (done=1 next cycle, no issue).
//      - Otherwise go to ISSUE.
//    - ISSUE (1 cycle): instr=mem[idx].instr, instr_vld=1, busy=1 -> WAIT with wcnt=LAT.
//    - WAIT (LAT cycles): instr=NOP_INSTR, instr_vld=0, busy=1.
//      - On the last WAIT cycle, rd is sampled. If chk=1, pass_cnt++ on match, otherwise
//        fail_cnt++; on the first mismatch, capture first_fail_idx=idx and set first_fail_vld.
//      - If chk=0, neither counter changes.
//      - Then: idx==len-1 -> DONE, else idx++ -> ISSUE.
//    - DONE: busy=0, done=1, instr=NOP_INSTR. Behaves as IDLE for load/start.
//  - Throughput: one entry per LAT+1 cycles. Entry k issues at cycle 1+k*(LAT+1) after start.
//  - load_we in IDLE/DONE writes mem[load_idx] at the clock edge.
//    - load_we and start in the same cycle: the write commits first and the run sees the new data.
//  - load_we and start while busy: ignored (no write, no restart).
//  - Counters cannot wrap: their width AW+1 holds DEPTH.
//  - Reset mid-run: outputs return to reset values immediately. The run is abandoned; a later
//    start reruns from entry 0.
// CONFIGURATION
//  STOP_ON_FAIL_EN:
//    - Defined: a mismatch on a checked entry ends the run. After that WAIT the FSM goes to
//      DONE, and later entries are not issued.
//    - Undefined: all len entries always run; mismatches are only counted.
// TESTING (bench drives rd from a riscv_top instance, or from a model with LAT=1)
//  1. rst=0 mid-cycle -> instr=0x00000013, instr_vld=0, busy=0, done=0, pass/fail=0 immediately.
//  2. Load {00A08093,exp 0000000A},{00A10113,exp 0000000A},{001101B3,exp 00000014}, all chk=1;
//     prog_len=3, start -> instr_vld at cycles 1,3,5; done at cycle 7; pass_cnt=3, fail_cnt=0.
//  3. As 2 but entry 1 exp=0000000B:
//     - no macro -> pass=2, fail=1, first_fail_idx=1, entry 2 issued;
//     - STOP_ON_FAIL_EN -> pass=1, fail=1, done at cycle 5, no third instr_vld.
//  4. prog_len=0, start -> done=1 next cycle, instr_vld never asserts, counters 0.
//  5. rst=0 after second issue, then release and restart with prog_len=3 -> memory intact,
//     pass_cnt=3.
//  6. During a run: start and load_we (idx 0 <- 0) are ignored (program unchanged, no restart).
//     An entry with chk=0 and wrong rd changes neither counter. prog_len=31 with DEPTH=16 runs
//     16 entries.

Source files
------------

// File: rtl/riscv_instr_sequencer.sv
// Program-driven instruction sequencer: issues stored instructions and checks rd.
// Optional STOP_ON_FAIL_EN macro ends the run at the first checked mismatch.
module riscv_instr_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int LAT = 1,
  parameter logic [WIDTH-1:0] NOP_INSTR = 32'h00000013,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_we,
  input  logic [AW-1:0]    load_idx,
  input  logic [WIDTH-1:0] load_instr,
  input  logic [WIDTH-1:0] load_exp,
  input  logic             load_chk,
  input  logic [AW:0]      prog_len,
  input  logic             start,
  output logic [WIDTH-1:0] instr,
  output logic             instr_vld,
  input  logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      pass_cnt,
  output logic [AW:0]      fail_cnt,
  output logic             first_fail_vld,
  output logic [AW-1:0]    first_fail_idx
);

  localparam int WW = $clog2(LAT + 1);
  localparam logic [WW-1:0] LAT_W = WW'(LAT);
  localparam logic [WW-1:0] W_ONE = WW'(1);
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] I_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_exp [DEPTH];
  logic             mem_chk [DEPTH];

  logic [AW-1:0] idx, idx_n;
  logic [AW:0]   len, len_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [AW:0]   pass_n, fail_n;
  logic          ffv_n;
  logic [AW-1:0] ffi_n;
  logic          idle;
  logic          mis;
  logic          stop;

  assign idle = (state == S_IDLE) || (state == S_DONE);

  assign instr     = (state == S_ISSUE) ? mem_instr[idx] : NOP_INSTR;
  assign instr_vld = (state == S_ISSUE);
  assign busy      = (state == S_ISSUE) || (state == S_WAIT);
  assign done      = (state == S_DONE);

  // Program memory: writable only while no run is active, never reset.
  always_ff @(posedge clk) begin
    if (load_we && idle) begin
      mem_instr[load_idx] <= load_instr;
      mem_exp[load_idx]   <= load_exp;
      mem_chk[load_idx]   <= load_chk;
    end
  end

  // Run control and result bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      idx            <= '0;
      len            <= '0;
      wcnt           <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      len            <= len_n;
      wcnt           <= wcnt_n;
      pass_cnt       <= pass_n;
      fail_cnt       <= fail_n;
      first_fail_vld <= ffv_n;
      first_fail_idx <= ffi_n;
    end
  end

  // Next-state: start/issue/wait sequencing and rd comparison.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    len_n   = len;
    wcnt_n  = wcnt;
    pass_n  = pass_cnt;
    fail_n  = fail_cnt;
    ffv_n   = first_fail_vld;
    ffi_n   = first_fail_idx;
    mis     = 1'b0;
    stop    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_n  = '0;
          fail_n  = '0;
          ffv_n   = 1'b0;
          ffi_n   = '0;
          idx_n   = '0;
          len_n   = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
          state_n = (prog_len == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_n  = LAT_W;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt == W_ONE) begin
          mis = mem_chk[idx] && (rd != mem_exp[idx]);
          if (mem_chk[idx]) begin
            if (mis) begin
              fail_n = fail_cnt + ONE;
              if (!first_fail_vld) begin
                ffv_n = 1'b1;
                ffi_n = idx;
              end
            end else begin
              pass_n = pass_cnt + ONE;
            end
          end
          stop = ({1'b0, idx} == (len - ONE));
`ifdef STOP_ON_FAIL_EN
          stop = stop || mis;
`endif
          if (stop) begin
            state_n = S_DONE;
          end else begin
            idx_n   = idx + I_ONE;
            state_n = S_ISSUE;
          end
        end else begin
          wcnt_n = wcnt - W_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_riscv_instr_sequencer.sv
// Bench for riscv_instr_sequencer: table vectors, directed corners, random runs.
// A tiny core model produces rd one cycle after each issue.
module tb_riscv_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0F0F;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_idx = '0;
  logic [31:0]   load_instr = '0;
  logic [31:0]   load_exp = '0;
  logic          load_chk = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [31:0]   instr;
  logic          instr_vld;
  logic [31:0]   rd = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   pass_cnt;
  logic [AW:0]   fail_cnt;
  logic          first_fail_vld;
  logic [AW-1:0] first_fail_idx;

  int compared = 0;
  int mismatched = 0;

  riscv_instr_sequencer dut (
    .clk(clk),
    .rst(rst),
    .load_we(load_we),
    .load_idx(load_idx),
    .load_instr(load_instr),
    .load_exp(load_exp),
    .load_chk(load_chk),
    .prog_len(prog_len),
    .start(start),
    .instr(instr),
    .instr_vld(instr_vld),
    .rd(rd),
    .busy(busy),
    .done(done),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  // Core model: addi/add on a register file, other opcodes echo instr^KEY.
  logic [31:0] xr [32];
  logic [31:0] res;

  function automatic logic [31:0] exec(input logic [31:0] i);
    logic [31:0] imm;
    imm = {{20{i[31]}}, i[31:20]};
    if (i[6:0] == 7'h13 && i[14:12] == 3'b000) return xr[i[19:15]] + imm;
    if (i[6:0] == 7'h33 && i[14:12] == 3'b000) return xr[i[19:15]] + xr[i[24:20]];
    return i ^ KEY;
  endfunction

  always @(posedge clk) begin
    if (instr_vld) begin
      res = exec(instr);
      if ((instr[6:0] == 7'h13 || instr[6:0] == 7'h33) && instr[11:7] != 5'd0)
        xr[instr[11:7]] = res;
      rd <= res;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] ins, input logic [31:0] ex, input logic ck);
    @(negedge clk);
    load_we = 1'b1;
    load_idx = AW'(idx);
    load_instr = ins;
    load_exp = ex;
    load_chk = ck;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  int          vcyc[$];
  logic [31:0] vins[$];
  int          done_cyc;

  // mode 0: plain run, 1: start+load during run, 2: reset in cycle 4
  task automatic run(input logic [AW:0] plen, input int mode);
    for (int r = 0; r < 32; r++) xr[r] = '0;
    vcyc.delete();
    vins.delete();
    done_cyc = -1;
    @(negedge clk);
    prog_len = plen;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (c == 1 || c == 3) begin
        start = 1'b0;
        load_we = 1'b0;
      end
      if (instr_vld) begin
        vcyc.push_back(c);
        vins.push_back(instr);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      if (mode == 1 && c == 2) begin
        start = 1'b1;
        load_we = 1'b1;
        load_idx = '0;
        load_instr = '0;
        load_exp = '0;
        load_chk = 1'b1;
      end
      if (mode == 2 && c == 4) begin
        #3 rst = 1'b0;
        #1;
        check("rst_instr", instr, NOP);
        check("rst_vld", 32'(instr_vld), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass_cnt), 0);
        check("rst_fail", 32'(fail_cnt), 0);
        check("rst_ffv", 32'(first_fail_vld), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    if (done_cyc < 0) check("run_timeout", 0, 1);
  endtask

  typedef struct {
    logic [AW:0] len;
    logic [15:0] bad;
    logic [15:0] chk;
    int          pass;
    int          fail;
    bit          ffv;
    int          ffi;
    int          nissue;
  } vec_t;

  vec_t vt[6];

  function automatic logic [31:0] tins(input int i);
    return 32'h1234_000B | (32'(i) << 8);
  endfunction

  logic [31:0] p_ins[DEPTH];
  logic [31:0] p_exp[DEPTH];
  logic        p_chk[DEPTH];

  initial begin
`ifdef STOP_ON_FAIL_EN
    vt[0] = '{5'd4, 16'h0000, 16'h000F, 4, 0, 1'b0, 0, 4};
    vt[1] = '{5'd4, 16'h0004, 16'h000F, 2, 1, 1'b1, 2, 3};
    vt[2] = '{5'd5, 16'h0006, 16'h001D, 1, 1, 1'b1, 2, 3};
    vt[3] = '{5'd16, 16'h8001, 16'hFFFF, 0, 1, 1'b1, 0, 1};
    vt[4] = '{5'd20, 16'h8000, 16'h7FFF, 15, 0, 1'b0, 0, 16};
    vt[5] = '{5'd1, 16'h0001, 16'h0000, 0, 0, 1'b0, 0, 1};
`else
    vt[0] = '{5'd4, 16'h0000, 16'h000F, 4, 0, 1'b0, 0, 4};
    vt[1] = '{5'd4, 16'h0004, 16'h000F, 3, 1, 1'b1, 2, 4};
    vt[2] = '{5'd5, 16'h0006, 16'h001D, 3, 1, 1'b1, 2, 5};
    vt[3] = '{5'd16, 16'h8001, 16'hFFFF, 14, 2, 1'b1, 0, 16};
    vt[4] = '{5'd20, 16'h8000, 16'h7FFF, 15, 0, 1'b0, 0, 16};
    vt[5] = '{5'd1, 16'h0001, 16'h0000, 0, 0, 1'b0, 0, 1};
`endif

    repeat (2) @(negedge clk);
    check("por_instr", instr, NOP);
    check("por_busy", 32'(busy), 0);
    check("por_done", 32'(done), 0);
    rst = 1'b1;

    // Basic three-instruction program
    load(0, 32'h00A0_8093, 32'h0000_000A, 1'b1);
    load(1, 32'h00A1_0113, 32'h0000_000A, 1'b1);
    load(2, 32'h0011_01B3, 32'h0000_0014, 1'b1);
    run(5'd3, 0);
    check("t2_nvld", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      check("t2_c0", vcyc[0], 1);
      check("t2_c1", vcyc[1], 3);
      check("t2_c2", vcyc[2], 5);
      check("t2_i2", vins[2], 32'h0011_01B3);
    end
    check("t2_done", done_cyc, 7);
    check("t2_pass", 32'(pass_cnt), 3);
    check("t2_fail", 32'(fail_cnt), 0);
    check("t2_ffv", 32'(first_fail_vld), 0);
    check("t2_busy", 32'(busy), 0);

    // Wrong expectation on entry 1
    load(1, 32'h00A1_0113, 32'h0000_000B, 1'b1);
    run(5'd3, 0);
    check("t3_fail", 32'(fail_cnt), 1);
    check("t3_ffv", 32'(first_fail_vld), 1);
    check("t3_ffi", 32'(first_fail_idx), 1);
`ifdef STOP_ON_FAIL_EN
    check("t3_pass", 32'(pass_cnt), 1);
    check("t3_nvld", vcyc.size(), 2);
    check("t3_done", done_cyc, 5);
`else
    check("t3_pass", 32'(pass_cnt), 2);
    check("t3_nvld", vcyc.size(), 3);
    check("t3_done", done_cyc, 7);
`endif
    load(1, 32'h00A1_0113, 32'h0000_000A, 1'b1);

    // Zero-length run
    run(5'd0, 0);
    check("t4_nvld", vcyc.size(), 0);
    check("t4_done", done_cyc, 1);
    check("t4_pass", 32'(pass_cnt), 0);
    check("t4_ffv", 32'(first_fail_vld), 0);

    // Reset mid-run, then rerun with retained memory
    run(5'd3, 2);
    run(5'd3, 0);
    check("t5_pass", 32'(pass_cnt), 3);
    check("t5_done", done_cyc, 7);

    // start/load during a run are ignored
    run(5'd3, 1);
    check("t6_nvld", vcyc.size(), 3);
    check("t6_done", done_cyc, 7);
    check("t6_pass", 32'(pass_cnt), 3);
    run(5'd3, 0);
    if (vins.size() > 0) check("t6_i0", vins[0], 32'h00A0_8093);
    else check("t6_i0_missing", 0, 1);
    check("t6_pass2", 32'(pass_cnt), 3);

    // Unchecked entry with wrong expectation
    load(2, 32'h0011_01B3, 32'h0000_0099, 1'b0);
    run(5'd3, 0);
    check("t6_chk0_pass", 32'(pass_cnt), 2);
    check("t6_chk0_fail", 32'(fail_cnt), 0);

    // Table-driven vectors
    foreach (vt[v]) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, tins(i), tins(i) ^ KEY ^ 32'(vt[v].bad[i]), vt[v].chk[i]);
      run(vt[v].len, 0);
      check($sformatf("v%0d_pass", v), 32'(pass_cnt), vt[v].pass);
      check($sformatf("v%0d_fail", v), 32'(fail_cnt), vt[v].fail);
      check($sformatf("v%0d_ffv", v), 32'(first_fail_vld), 32'(vt[v].ffv));
      if (vt[v].ffv) check($sformatf("v%0d_ffi", v), 32'(first_fail_idx), vt[v].ffi);
      check($sformatf("v%0d_nvld", v), vcyc.size(), vt[v].nissue);
      check($sformatf("v%0d_done", v), done_cyc, 1 + 2 * vt[v].nissue);
    end

    // Randomised programs against a reference count
    for (int t = 0; t < 25; t++) begin
      int len, n, ep, ef, fi;
      bit fv;
      logic [AW:0] pl;
      logic [31:0] r;
      logic [31:0] bad;
      pl = AW'(0) + (AW + 1)'($urandom_range(0, 22));
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom();
        r[6:0] = 7'h0B;
        bad = ($urandom_range(0, 3) == 0) ? ($urandom() | 32'h1) : 32'h0;
        p_ins[i] = r;
        p_exp[i] = r ^ KEY ^ bad;
        p_chk[i] = ($urandom_range(0, 4) != 0);
        load(i, p_ins[i], p_exp[i], p_chk[i]);
      end
      len = (int'(pl) > DEPTH) ? DEPTH : int'(pl);
      n = 0; ep = 0; ef = 0; fv = 0; fi = 0;
      for (int i = 0; i < len; i++) begin
        n++;
        if (p_chk[i]) begin
          if (p_exp[i] == (p_ins[i] ^ KEY)) ep++;
          else begin
            ef++;
            if (!fv) begin fv = 1; fi = i; end
`ifdef STOP_ON_FAIL_EN
            break;
`endif
          end
        end
      end
      run(pl, 0);
      check($sformatf("r%0d_pass", t), 32'(pass_cnt), ep);
      check($sformatf("r%0d_fail", t), 32'(fail_cnt), ef);
      check($sformatf("r%0d_ffv", t), 32'(first_fail_vld), 32'(fv));
      if (fv) check($sformatf("r%0d_ffi", t), 32'(first_fail_idx), fi);
      check($sformatf("r%0d_nvld", t), vcyc.size(), n);
      check($sformatf("r%0d_done", t), done_cyc, 1 + 2 * n);
      for (int i = 0; i < vins.size() && i < len; i++)
        check($sformatf("r%0d_ins%0d", t, i), vins[i], p_ins[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
